// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder
//   Memory-side responder for the 6502 core. Decodes the core's address bus
//   into vector ROM, an 8-byte I/O page, on-chip RAM and open bus, returns
//   registered read data and runs a 16-bit interval timer that drives IRQ.
//   Every bus/timer action is qualified by 'step', the same one-clk pulse
//   that advances the core, so single-step and free-run stay in lockstep.
//
// Ports
//   clk, rst_n      system clock, synchronous active-low reset
//   step            advance pulse shared with the core
//   addr/wdata/we   core bus outputs
//   rdata           read data to the core (valid one step after addr)
//   irq             level interrupt request (IF & IE), registered
//   port_out        GPIO output register
//   port_in         asynchronous GPIO inputs (2-flop synchronised)
//   watch_addr/watch_data/watch_cnt
//                   write-probe outputs, present only with BUS_WATCH_EN
//
// Optional feature macro: BUS_WATCH_EN
//
// I/O page map (IO_BASE + n)
//   0 PORT_OUT rw | 1 PORT_IN ro | 2 TMR_LO | 3 TMR_HI | 4 CTRL | 5..7 zero
//   CTRL = {IF, 5'b0, IE, EN}; writing 1 to bit7 clears IF.
module cpu_bus_responder #(
  parameter int          RAM_AW    = 10,
  parameter logic [15:0] IO_BASE   = 16'hD000,
  parameter logic [15:0] RESET_VEC = 16'h0200,
  parameter logic [15:0] IRQ_VEC   = 16'h0300,
  parameter logic [15:0] NMI_VEC   = 16'h0300,
  parameter logic [7:0]  OPEN_BUS  = 8'hFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        we,
  output logic [7:0]  rdata,
  output logic        irq,
  output logic [7:0]  port_out,
  input  logic [7:0]  port_in
`ifdef BUS_WATCH_EN
  ,
  output logic [15:0] watch_addr,
  output logic [7:0]  watch_data,
  output logic [7:0]  watch_cnt
`endif
);

  localparam int RAM_DEPTH = 1 << RAM_AW;

  typedef struct packed {
    logic       vec;
    logic       io;
    logic       ram;
    logic [2:0] off;
  } dec_t;

  // ---------------------------------------------------------------- state
  logic [7:0]  mem [RAM_DEPTH];
  logic [7:0]  sync1, sync2;
  logic [15:0] cnt_q, rld_q;
  logic [7:0]  shadow_q;
  logic        en_q, ie_q, if_q;

  // ---------------------------------------------------------------- decode
  dec_t dec;

  always_comb begin
    dec     = '0;
    dec.off = addr[2:0];
    if (addr >= 16'hFFFA)
      dec.vec = 1'b1;
    else if (addr[15:3] == IO_BASE[15:3])
      dec.io = 1'b1;
    else if ((addr >> RAM_AW) == 16'd0)
      dec.ram = 1'b1;
  end

  logic wr, rd, io_wr, port_wr, lo_wr, hi_wr, ctrl_wr, lo_rd;

  assign wr      = step & we;
  assign rd      = step & ~we;
  assign io_wr   = wr & dec.io;
  assign port_wr = io_wr & (dec.off == 3'd0);
  assign lo_wr   = io_wr & (dec.off == 3'd2);
  assign hi_wr   = io_wr & (dec.off == 3'd3);
  assign ctrl_wr = io_wr & (dec.off == 3'd4);
  assign lo_rd   = rd & dec.io & (dec.off == 3'd2);

  // ---------------------------------------------------------------- timer
  // A CTRL write that clears EN suppresses the tick on that very step, so a
  // disable landing on the expiry step neither reloads nor raises IF. A write
  // that sets EN only starts counting from the next step.
  logic        tick, expire;
  logic [15:0] cnt_d, rld_d;
  logic        en_d, ie_d, if_d;

  always_comb begin
    tick   = step & en_q & ~(ctrl_wr & ~wdata[0]);
    // A TMR_HI load overrides the reload and masks IF for this step.
    expire = tick & (cnt_q == 16'd0) & ~hi_wr;

    cnt_d = cnt_q;
    if (hi_wr)
      cnt_d = {wdata, rld_q[7:0]};
    else if (tick)
      cnt_d = (cnt_q == 16'd0) ? rld_q : cnt_q - 16'd1;

    rld_d = rld_q;
    if (lo_wr) rld_d[7:0]  = wdata;
    if (hi_wr) rld_d[15:8] = wdata;

    en_d = ctrl_wr ? wdata[0] : en_q;
    ie_d = ctrl_wr ? wdata[1] : ie_q;
    // Set has priority over a same-step write-1-to-clear.
    if_d = expire | (if_q & ~(ctrl_wr & wdata[7]));
  end

  // ---------------------------------------------------------------- read mux
  logic [7:0] rd_val;

  always_comb begin
    rd_val = OPEN_BUS;
    if (dec.vec) begin
      case (addr[2:0])
        3'd2:    rd_val = NMI_VEC[7:0];
        3'd3:    rd_val = NMI_VEC[15:8];
        3'd4:    rd_val = RESET_VEC[7:0];
        3'd5:    rd_val = RESET_VEC[15:8];
        3'd6:    rd_val = IRQ_VEC[7:0];
        3'd7:    rd_val = IRQ_VEC[15:8];
        default: rd_val = OPEN_BUS;
      endcase
    end else if (dec.io) begin
      case (dec.off)
        3'd0:    rd_val = port_out;
        3'd1:    rd_val = sync2;
        3'd2:    rd_val = cnt_q[7:0];
        3'd3:    rd_val = shadow_q;
        3'd4:    rd_val = {if_q, 5'b0, ie_q, en_q};
        default: rd_val = 8'h00;
      endcase
    end else if (dec.ram) begin
      rd_val = mem[addr[RAM_AW-1:0]];
    end
  end

  // ---------------------------------------------------------------- registers
  // The synchroniser runs every clk so PORT_IN is already settled when a
  // single-stepped read arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 8'h00;
      sync2 <= 8'h00;
    end else begin
      sync1 <= port_in;
      sync2 <= sync1;
    end
  end

  // RAM has no reset; writes are blocked while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && wr && dec.ram)
      mem[addr[RAM_AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata    <= 8'h00;
      port_out <= 8'h00;
      irq      <= 1'b0;
      cnt_q    <= 16'hFFFF;
      rld_q    <= 16'hFFFF;
      shadow_q <= 8'h00;
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      if_q     <= 1'b0;
    end else if (step) begin
      if (rd)      rdata    <= rd_val;
      if (port_wr) port_out <= wdata;
      // Latch the high byte as the low byte is read: tear-free 16-bit read.
      if (lo_rd)   shadow_q <= cnt_q[15:8];
      cnt_q <= cnt_d;
      rld_q <= rld_d;
      en_q  <= en_d;
      ie_q  <= ie_d;
      if_q  <= if_d;
      irq   <= if_d & ie_d;
    end
  end

`ifdef BUS_WATCH_EN
  // Write probe: captures every write step on the bus regardless of target.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      watch_addr <= 16'h0000;
      watch_data <= 8'h00;
      watch_cnt  <= 8'h00;
    end else if (wr) begin
      watch_addr <= addr;
      watch_data <= wdata;
      watch_cnt  <= watch_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: each task drives one scenario and
// compares outputs against hand-derived values sampled on the falling edge.
module tb_cpu_bus_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        step = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic        we = 1'b0;
  logic [7:0]  port_in = 8'h00;
  logic [7:0]  rdata;
  logic        irq;
  logic [7:0]  port_out;
`ifdef BUS_WATCH_EN
  logic [15:0] watch_addr;
  logic [7:0]  watch_data;
  logic [7:0]  watch_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  cpu_bus_responder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (step),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .rdata    (rdata),
    .irq      (irq),
    .port_out (port_out),
    .port_in  (port_in)
`ifdef BUS_WATCH_EN
    ,
    .watch_addr (watch_addr),
    .watch_data (watch_data),
    .watch_cnt  (watch_cnt)
`endif
  );

  always #5 clk = ~clk;

  // One step: inputs set on a falling edge, step high across one rising edge,
  // returns on the next falling edge where outputs are stable.
  task automatic bus(input logic [15:0] a, input logic [7:0] d, input logic w);
    @(negedge clk);
    addr = a; wdata = d; we = w; step = 1'b1;
    @(negedge clk);
    step = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    bus(a, 8'h00, 1'b0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus(a, d, 1'b1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; step = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vectors++; if (rdata !== 8'h00) begin miscompares++; $display("FAIL reset_rdata: got %h want 00", rdata); end
    vectors++; if (port_out !== 8'h00) begin miscompares++; $display("FAIL reset_port_out: got %h want 00", port_out); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b want 0", irq); end
    rd(16'hFFFC);
    vectors++; if (rdata !== 8'h00) begin miscompares++; $display("FAIL reset_vec_lo: got %h want 00", rdata); end
    rd(16'hFFFD);
    vectors++; if (rdata !== 8'h02) begin miscompares++; $display("FAIL reset_vec_hi: got %h want 02", rdata); end
  endtask

  task automatic test_vectors;
    logic [15:0] va [4];
    logic [7:0]  ve [4];
    va = '{16'hFFFA, 16'hFFFB, 16'hFFFE, 16'hFFFF};
    ve = '{8'h00, 8'h03, 8'h00, 8'h03};
    for (int i = 0; i < 4; i++) begin
      rd(va[i]);
      vectors++; if (rdata !== ve[i]) begin miscompares++; $display("FAIL vec_%h: got %h want %h", va[i], rdata, ve[i]); end
    end
    // Write to a vector is ignored and rdata holds across the write step.
    wr(16'hFFFC, 8'h55);
    vectors++; if (rdata !== 8'h03) begin miscompares++; $display("FAIL vec_wr_hold: got %h want 03", rdata); end
    rd(16'hFFFC);
    vectors++; if (rdata !== 8'h00) begin miscompares++; $display("FAIL vec_wr_ignored: got %h want 00", rdata); end
  endtask

  task automatic test_ram;
    wr(16'h0123, 8'hA5);
    vectors++; if (rdata !== 8'h00) begin miscompares++; $display("FAIL ram_wr_hold: got %h want 00", rdata); end
    rd(16'h0123);
    vectors++; if (rdata !== 8'hA5) begin miscompares++; $display("FAIL ram_rt: got %h want a5", rdata); end
    rd(16'h8000);
    vectors++; if (rdata !== 8'hFF) begin miscompares++; $display("FAIL open_bus_8000: got %h want ff", rdata); end
    wr(16'h03FF, 8'h5A);
    rd(16'h03FF);
    vectors++; if (rdata !== 8'h5A) begin miscompares++; $display("FAIL ram_top: got %h want 5a", rdata); end
    rd(16'h0400);
    vectors++; if (rdata !== 8'hFF) begin miscompares++; $display("FAIL above_ram: got %h want ff", rdata); end
    // No step: address changes must not disturb rdata.
    @(negedge clk); addr = 16'h0123;
    repeat (2) @(negedge clk);
    vectors++; if (rdata !== 8'hFF) begin miscompares++; $display("FAIL nostep_hold: got %h want ff", rdata); end
  endtask

  task automatic test_gpio;
    wr(16'hD000, 8'h3C);
    vectors++; if (port_out !== 8'h3C) begin miscompares++; $display("FAIL port_out: got %h want 3c", port_out); end
    rd(16'hD000);
    vectors++; if (rdata !== 8'h3C) begin miscompares++; $display("FAIL port_out_rd: got %h want 3c", rdata); end
    port_in = 8'h81;
    repeat (3) @(negedge clk);
    rd(16'hD001);
    vectors++; if (rdata !== 8'h81) begin miscompares++; $display("FAIL port_in: got %h want 81", rdata); end
    rd(16'hD005);
    vectors++; if (rdata !== 8'h00) begin miscompares++; $display("FAIL io_rsvd: got %h want 00", rdata); end
    rd(16'hD004);
    vectors++; if (rdata !== 8'h00) begin miscompares++; $display("FAIL ctrl_init: got %h want 00", rdata); end
  endtask

  task automatic test_timer_irq;
    logic e1 [4];
    logic e2 [3];
    e1 = '{1'b0, 1'b0, 1'b0, 1'b1};
    e2 = '{1'b0, 1'b0, 1'b1};
    wr(16'hD002, 8'h03);
    wr(16'hD003, 8'h00);                 // count = 3
    wr(16'hD004, 8'h03);                 // EN takes effect from the next step
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL tmr_start_irq: got %b want 0", irq); end
    for (int i = 0; i < 4; i++) begin    // 3->2, 2->1, 1->0, expire
      rd(16'h0123);
      vectors++; if (irq !== e1[i]) begin miscompares++; $display("FAIL tmr_irq_step%0d: got %b want %b", i, irq, e1[i]); end
    end
    // 0x83 clears IF while keeping EN/IE (0x80 alone would also clear EN/IE).
    wr(16'hD004, 8'h83);                 // count 3->2
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL tmr_clear: got %b want 0", irq); end
    for (int i = 0; i < 3; i++) begin    // 2->1, 1->0, expire
      rd(16'h0123);
      vectors++; if (irq !== e2[i]) begin miscompares++; $display("FAIL tmr_rearm_step%0d: got %b want %b", i, irq, e2[i]); end
    end
  endtask

  task automatic test_simultaneous;
    wr(16'hD004, 8'h83);                 // clear, 3->2
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL sim_clear: got %b want 0", irq); end
    rd(16'h0123);                        // 2->1
    rd(16'h0123);                        // 1->0
    wr(16'hD004, 8'h83);                 // expiry + clear: set wins
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL set_beats_clear: got %b want 1", irq); end
    rd(16'hD004);                        // 3->2
    vectors++; if (rdata !== 8'h83) begin miscompares++; $display("FAIL ctrl_rd_if: got %h want 83", rdata); end
    wr(16'hD004, 8'h83);                 // clear, 2->1
    rd(16'h0123);                        // 1->0
    wr(16'hD004, 8'h02);                 // EN=0 on expiry: no reload, no IF
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL en_off_expiry: got %b want 0", irq); end
    rd(16'hD002);
    vectors++; if (rdata !== 8'h00) begin miscompares++; $display("FAIL en_off_no_reload: got %h want 00", rdata); end
    wr(16'hD004, 8'h03);                 // EN on, count still 0
    wr(16'hD003, 8'h00);                 // HI load on expiry step: count = 3, no IF
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL load_beats_expiry: got %b want 0", irq); end
    rd(16'hD002);                        // reads 3, then 3->2
    vectors++; if (rdata !== 8'h03) begin miscompares++; $display("FAIL load_value: got %h want 03", rdata); end
    rd(16'h0123);                        // 2->1
    rd(16'h0123);                        // 1->0
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL pre_expiry_irq: got %b want 0", irq); end
    rd(16'h0123);                        // expire
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL post_load_expiry: got %b want 1", irq); end
  endtask

  task automatic test_reset_midcount;
    @(negedge clk);
    rst_n = 1'b0; step = 1'b1; addr = 16'h0123; we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; step = 1'b0;
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL midrst_irq: got %b want 0", irq); end
    vectors++; if (port_out !== 8'h00) begin miscompares++; $display("FAIL midrst_port_out: got %h want 00", port_out); end
    rd(16'hD002);
    vectors++; if (rdata !== 8'hFF) begin miscompares++; $display("FAIL midrst_cnt_lo: got %h want ff", rdata); end
    rd(16'hD003);
    vectors++; if (rdata !== 8'hFF) begin miscompares++; $display("FAIL midrst_cnt_hi: got %h want ff", rdata); end
    rd(16'hD004);
    vectors++; if (rdata !== 8'h00) begin miscompares++; $display("FAIL midrst_ctrl: got %h want 00", rdata); end
  endtask

  task automatic test_tear_free;
    wr(16'hD002, 8'h00);
    wr(16'hD003, 8'h01);                 // count = 0x0100, EN still 0
    wr(16'hD004, 8'h01);                 // EN on from next step
    rd(16'hD002);                        // returns 0x00, count -> 0x00FF
    vectors++; if (rdata !== 8'h00) begin miscompares++; $display("FAIL tear_lo: got %h want 00", rdata); end
    rd(16'hD003);                        // shadow 0x01, count -> 0x00FE
    vectors++; if (rdata !== 8'h01) begin miscompares++; $display("FAIL tear_hi: got %h want 01", rdata); end
    rd(16'hD002);
    vectors++; if (rdata !== 8'hFE) begin miscompares++; $display("FAIL tear_lo_next: got %h want fe", rdata); end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_ram;
    test_gpio;
    test_timer_irq;
    test_simultaneous;
    test_reset_midcount;
    test_tear_free;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
